// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
//   Shared types and constants for the sequential signed divider.
//   DIV_W        : default divisor/quotient/remainder width
//   ITER_W       : width of the divide-step counter (counts 0 .. 2*DIV_W-1)
//   QMAX / QMIN  : saturation limits of a DIV_W-bit signed quotient
//   state_t      : divider FSM state encoding
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DIV_W  = 8;
    localparam int ITER_W = $clog2(2 * DIV_W) + 1;

    localparam logic [DIV_W-1:0] QMAX = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] QMIN = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step on magnitudes.
//   i_rem  : current partial remainder (always < i_dvs)
//   i_msb  : next dividend bit shifted into the remainder
//   i_dvs  : divisor magnitude
//   o_rem  : next partial remainder
//   o_qbit : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_msb,
    input  logic [W-1:0] i_dvs,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0] w_sh;

    // Shifted remainder is < 2*dvs, so it needs one extra bit; the trial result
    // (kept or restored) always fits back into W bits.
    assign w_sh   = {i_rem, i_msb};
    assign o_qbit = (w_sh >= {1'b0, i_dvs});
    assign o_rem  = o_qbit ? W'(w_sh - {1'b0, i_dvs}) : w_sh[W-1:0];

endmodule

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
//   Sequential signed restoring divider: 2W-bit dividend / W-bit divisor,
//   one quotient bit per clock, start/done handshake.
//   clk, rst_n (async, active low)
//   start     : load operands and begin (accepted in IDLE or DONE only)
//   dvd, dvs  : signed dividend (2W) and divisor (W), sampled on the start edge
//   quo, rem  : signed quotient (toward zero) and remainder (sign of dividend)
//   done      : high in DONE;  busy : high in DIVIDE and FIX
//   div_zero  : divisor was zero;  ovf : quotient does not fit W bits
//   Build option SEQ_DIV_SAT_EN: saturate quo on ovf (default: wrap).
// -----------------------------------------------------------------------------
module seq_div
    import seq_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [2*W-1:0] dvd,
    input  logic signed [W-1:0]   dvs,
    output logic signed [W-1:0]   quo,
    output logic signed [W-1:0]   rem,
    output logic                  done,
    output logic                  busy,
    output logic                  div_zero,
    output logic                  ovf
);

    state_t              r_state, w_next;
    logic [ITER_W-1:0]   r_iter;
    logic [2*W-1:0]      r_q;        // dividend bits shifting out, quotient bits shifting in
    logic [W-1:0]        r_rem;      // partial remainder magnitude
    logic [W-1:0]        r_dvs;      // divisor magnitude
    logic                r_sd, r_ss, r_dz;
    logic [W-1:0]        r_quo, r_remo;
    logic                r_dzo, r_ovf;

    logic                w_accept, w_last, w_neg, w_ovf, w_qbit;
    logic [2*W-1:0]      w_dvd_mag;
    logic [W-1:0]        w_dvs_mag, w_step_rem, w_quo_wrap, w_quo_fix, w_rem_s, w_rem_dz;

    // Magnitudes as unsigned values: the most-negative inputs negate to
    // themselves, which read unsigned are exactly 2^(2W-1) and 2^(W-1).
    assign w_dvd_mag = dvd[2*W-1] ? -dvd : dvd;
    assign w_dvs_mag = dvs[W-1]   ? -dvs : dvs;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_iter == ITER_W'(2*W-1));

    div_step #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_q[2*W-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // Sign fix-up of the 2W-bit magnitude quotient.
    assign w_neg      = r_sd ^ r_ss;
    assign w_ovf      = w_neg ? ((|r_q[2*W-1:W]) || (r_q[W-1] && (|r_q[W-2:0])))
                              : (|r_q[2*W-1:W-1]);
    assign w_quo_wrap = w_neg ? W'(-r_q) : r_q[W-1:0];
`ifdef SEQ_DIV_SAT_EN
    assign w_quo_fix  = w_ovf ? (w_neg ? QMIN : QMAX) : w_quo_wrap;
`else
    assign w_quo_fix  = w_quo_wrap;
`endif
    assign w_rem_s    = r_sd ? -r_rem : r_rem;
    // No divide ran, so r_q still holds |dvd|; re-applying the sign gives dvd[W-1:0].
    assign w_rem_dz   = r_sd ? -r_q[W-1:0] : r_q[W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = (dvs == '0) ? FIX : DIVIDE;
            DIVIDE:     if (w_last) w_next = FIX;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        done = (r_state == DONE);
        busy = (r_state == DIVIDE) || (r_state == FIX);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_sd   <= 1'b0;
            r_ss   <= 1'b0;
            r_dz   <= 1'b0;
            r_quo  <= '0;
            r_remo <= '0;
            r_dzo  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_iter <= '0;
            r_q    <= w_dvd_mag;
            r_rem  <= '0;
            r_dvs  <= w_dvs_mag;
            r_sd   <= dvd[2*W-1];
            r_ss   <= dvs[W-1];
            r_dz   <= (dvs == '0);
            r_quo  <= '0;
            r_remo <= '0;
            r_dzo  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == DIVIDE) begin
            r_iter <= r_iter + 1'b1;
            r_q    <= {r_q[2*W-2:0], w_qbit};
            r_rem  <= w_step_rem;
        end else if (r_state == FIX) begin
            if (r_dz) begin
                r_quo  <= '0;
                r_remo <= w_rem_dz;
                r_dzo  <= 1'b1;
                r_ovf  <= 1'b0;
            end else begin
                r_quo  <= w_quo_fix;
                r_remo <= w_rem_s;
                r_dzo  <= 1'b0;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign quo      = r_quo;
    assign rem      = r_remo;
    assign div_zero = r_dzo;
    assign ovf      = r_ovf;

endmodule
